// File: rtl/gpu_mem_pkg.sv
// Shared types and defaults for the multi-channel memory responder.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_chan_state_t;

    localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_channel_fsm.sv
// One request engine (read or write): latches the request payload, counts down the
// fixed latency, pulses ready once and then waits for valid to drop before re-arming.
module mem_channel_fsm
    import gpu_mem_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int LATENCY      = DEFAULT_LATENCY,
    parameter bit ENABLE       = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic [PAYLOAD_BITS-1:0] payload_i,
    output mem_chan_state_t         state_o,
    output logic                    cnt_done_o,
    output logic [PAYLOAD_BITS-1:0] payload_o,
    output logic                    ready_o
);

    localparam int                  CNT_BITS = $clog2(LATENCY + 1);
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    mem_chan_state_t         state_q, state_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
    logic                    ready_q, ready_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            payload_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && ENABLE) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_LOAD;
                    payload_d = payload_i;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            // Holding here while valid stays high blocks a duplicate request.
            DONE: begin
                if (!valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o    = state_q;
    assign cnt_done_o = (cnt_q == '0);
    assign payload_o  = payload_q;
    assign ready_o    = ready_q;

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency multi-channel memory model: shared storage, per-channel read and
// write engines, prioritised same-edge writes and read-before-write hazards.
module memory_responder
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = DEFAULT_LATENCY,
    parameter bit WRITE_ENABLE = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    output logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_ready,
    input  logic                                    load_valid,
    input  logic [ADDR_BITS-1:0]                    load_address,
    input  logic [DATA_BITS-1:0]                    load_data
);

    localparam int DEPTH   = 1 << ADDR_BITS;
    localparam int WR_BITS = ADDR_BITS + DATA_BITS;

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    mem_chan_state_t      rd_state    [NUM_CHANNELS];
    mem_chan_state_t      wr_state    [NUM_CHANNELS];
    logic                 rd_cnt_done [NUM_CHANNELS];
    logic                 wr_cnt_done [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] rd_addr     [NUM_CHANNELS];
    logic [WR_BITS-1:0]   wr_payload  [NUM_CHANNELS];
    logic                 rd_fire     [NUM_CHANNELS];
    logic                 wr_fire     [NUM_CHANNELS];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        logic [DATA_BITS-1:0] rdata_q;

        mem_channel_fsm #(
            .PAYLOAD_BITS (ADDR_BITS),
            .LATENCY      (LATENCY),
            .ENABLE       (1'b1)
        ) u_rd (
            .clk        (clk),
            .reset      (reset),
            .valid_i    (mem_read_valid[i]),
            .payload_i  (mem_read_address[i]),
            .state_o    (rd_state[i]),
            .cnt_done_o (rd_cnt_done[i]),
            .payload_o  (rd_addr[i]),
            .ready_o    (mem_read_ready[i])
        );

        mem_channel_fsm #(
            .PAYLOAD_BITS (WR_BITS),
            .LATENCY      (LATENCY),
            .ENABLE       (WRITE_ENABLE)
        ) u_wr (
            .clk        (clk),
            .reset      (reset),
            .valid_i    (mem_write_valid[i]),
            .payload_i  ({mem_write_data[i], mem_write_address[i]}),
            .state_o    (wr_state[i]),
            .cnt_done_o (wr_cnt_done[i]),
            .payload_o  (wr_payload[i]),
            .ready_o    (mem_write_ready[i])
        );

        // Completion edge: the same edge on which the engine registers ready.
        assign rd_fire[i] = (rd_state[i] == BUSY) && rd_cnt_done[i];
        assign wr_fire[i] = (wr_state[i] == BUSY) && wr_cnt_done[i];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdata_q <= '0;
            end else if (rd_fire[i]) begin
                rdata_q <= mem_q[rd_addr[i]];
            end
        end

        assign mem_read_data[i] = rdata_q;
    end

    // Later assignments win: higher channels first, then lower, then the preload.
    always_ff @(posedge clk) begin
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (wr_fire[i]) begin
                mem_q[wr_payload[i][ADDR_BITS-1:0]] <= wr_payload[i][WR_BITS-1:ADDR_BITS];
            end
        end
        if (load_valid) begin
            mem_q[load_address] <= load_data;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: data-memory instance (writes enabled)
// and program-memory instance (16-bit, writes disabled) driven from one clock.
module tb_memory_responder;

    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Data-memory instance
    logic [NC-1:0]        rd_valid;
    logic [NC-1:0][7:0]   rd_addr;
    logic [NC-1:0]        rd_ready;
    logic [NC-1:0][7:0]   rd_data;
    logic [NC-1:0]        wr_valid;
    logic [NC-1:0][7:0]   wr_addr;
    logic [NC-1:0][7:0]   wr_data;
    logic [NC-1:0]        wr_ready;
    logic                 load_valid;
    logic [7:0]           load_addr;
    logic [7:0]           load_data;

    // Program-memory instance
    logic [NC-1:0]        b_rd_valid;
    logic [NC-1:0][7:0]   b_rd_addr;
    logic [NC-1:0]        b_rd_ready;
    logic [NC-1:0][15:0]  b_rd_data;
    logic [NC-1:0]        b_wr_valid;
    logic [NC-1:0][7:0]   b_wr_addr;
    logic [NC-1:0][15:0]  b_wr_data;
    logic [NC-1:0]        b_wr_ready;
    logic                 b_load_valid;
    logic [7:0]           b_load_addr;
    logic [15:0]          b_load_data;

    memory_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(NC), .LATENCY(2), .WRITE_ENABLE(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rd_valid), .mem_read_address(rd_addr),
        .mem_read_ready(rd_ready), .mem_read_data(rd_data),
        .mem_write_valid(wr_valid), .mem_write_address(wr_addr),
        .mem_write_data(wr_data), .mem_write_ready(wr_ready),
        .load_valid(load_valid), .load_address(load_addr), .load_data(load_data)
    );

    memory_responder #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(NC), .LATENCY(2), .WRITE_ENABLE(1'b0)
    ) dut_pm (
        .clk(clk), .reset(reset),
        .mem_read_valid(b_rd_valid), .mem_read_address(b_rd_addr),
        .mem_read_ready(b_rd_ready), .mem_read_data(b_rd_data),
        .mem_write_valid(b_wr_valid), .mem_write_address(b_wr_addr),
        .mem_write_data(b_wr_data), .mem_write_ready(b_wr_ready),
        .load_valid(b_load_valid), .load_address(b_load_addr), .load_data(b_load_data)
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0]  exp_q[$];      // {channel, read data} in completion order
    logic [7:0]  model   [256];
    logic [15:0] model_b [256];
    int          wr_cnt  [NC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read completions are popped from the scoreboard; write pulses are counted.
    always @(negedge clk) begin
        logic [9:0] e;
        for (int c = 0; c < NC; c++) begin
            if (rd_ready[c]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("rd_unexpected_ch%0d", c), 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_chan_ch%0d", c), 32'(c), 32'(e[9:8]));
                    check($sformatf("rd_data_ch%0d", c), 32'(rd_data[c]), 32'(e[7:0]));
                end
            end
            if (wr_ready[c]) wr_cnt[c]++;
        end
    end

    task automatic do_load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        load_valid = 1'b1; load_addr = a; load_data = d;
        model[a] = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic do_load_b(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        b_load_valid = 1'b1; b_load_addr = a; b_load_data = d;
        model_b[a] = d;
        @(negedge clk);
        b_load_valid = 1'b0;
    endtask

    task automatic do_read(input int c, input logic [7:0] a);
        int n;
        @(negedge clk);
        rd_valid[c] = 1'b1; rd_addr[c] = a;
        exp_q.push_back({2'(c), model[a]});
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_ready[c] && n < 12);
        if (!rd_ready[c]) check("rd_timeout", 32'(0), 32'(1));
        rd_valid[c] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input int c, input logic [7:0] a, input logic [7:0] d, input int hold);
        int n;
        @(negedge clk);
        wr_valid[c] = 1'b1; wr_addr[c] = a; wr_data[c] = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!wr_ready[c] && n < 12);
        if (!wr_ready[c]) check("wr_timeout", 32'(0), 32'(1));
        else model[a] = d;
        wr_data[c] = ~d;  // must be ignored while the engine sits in DONE
        repeat (hold) @(negedge clk);
        wr_valid[c] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read_b(input int c, input logic [7:0] a);
        int n;
        logic [15:0] e;
        e = model_b[a];
        @(negedge clk);
        b_rd_valid[c] = 1'b1; b_rd_addr[c] = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_rd_ready[c] && n < 12);
        if (!b_rd_ready[c]) check("b_rd_timeout", 32'(0), 32'(1));
        else check("b_rd_data", 32'(b_rd_data[c]), 32'(e));
        b_rd_valid[c] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, b2;
        int rc;
        logic [7:0] ra;

        reset = 1'b0;
        rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        b_rd_valid = '0; b_rd_addr = '0; b_wr_valid = '0; b_wr_addr = '0; b_wr_data = '0;
        b_load_valid = 1'b0; b_load_addr = '0; b_load_data = '0;

        repeat (3) @(negedge clk);
        check("rst_rd_ready", 32'(rd_ready), 32'(0));
        check("rst_wr_ready", 32'(wr_ready), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_b_rd_data_lo", 32'(b_rd_data[1:0]), 32'(0));
        reset = 1'b1;
        @(negedge clk);

        // Basic read latency: ready exactly two edges after the request edge
        do_load(8'h10, 8'hA5);
        @(negedge clk);
        rd_valid[0] = 1'b1; rd_addr[0] = 8'h10;
        exp_q.push_back({2'd0, 8'hA5});
        @(negedge clk); check("lat_t0", 32'(rd_ready[0]), 32'(0));
        @(negedge clk); check("lat_t1", 32'(rd_ready[0]), 32'(0));
        @(negedge clk); check("lat_t2", 32'(rd_ready[0]), 32'(1));
        check("lat_data", 32'(rd_data[0]), 32'(8'hA5));
        rd_valid[0] = 1'b0;
        @(negedge clk); check("lat_t3", 32'(rd_ready[0]), 32'(0));
        check("lat_data_held", 32'(rd_data[0]), 32'(8'hA5));

        // Valid held after ready: one pulse, no second write
        b1 = wr_cnt[1];
        do_write(1, 8'h20, 8'h3C, 3);
        check("hold_one_pulse", 32'(wr_cnt[1] - b1), 32'(1));
        do_read(2, 8'h20);

        // Same-address collision: lowest channel wins, both pulse
        b0 = wr_cnt[0]; b2 = wr_cnt[2];
        @(negedge clk);
        wr_valid[0] = 1'b1; wr_addr[0] = 8'h30; wr_data[0] = 8'h11;
        wr_valid[2] = 1'b1; wr_addr[2] = 8'h30; wr_data[2] = 8'h22;
        repeat (3) @(negedge clk);
        check("coll_both_ready", 32'(wr_ready & 4'b0101), 32'(4'b0101));
        wr_valid[0] = 1'b0; wr_valid[2] = 1'b0;
        model[8'h30] = 8'h11;
        @(negedge clk);
        check("coll_cnt0", 32'(wr_cnt[0] - b0), 32'(1));
        check("coll_cnt2", 32'(wr_cnt[2] - b2), 32'(1));
        do_read(1, 8'h30);

        // Read and write to one address completing together: read sees old value
        do_load(8'h40, 8'h01);
        @(negedge clk);
        rd_valid[3] = 1'b1; rd_addr[3] = 8'h40;
        exp_q.push_back({2'd3, 8'h01});
        wr_valid[0] = 1'b1; wr_addr[0] = 8'h40; wr_data[0] = 8'h02;
        repeat (3) @(negedge clk);
        check("rw_same_edge", 32'({rd_ready[3], wr_ready[0]}), 32'(2'b11));
        rd_valid[3] = 1'b0; wr_valid[0] = 1'b0;
        model[8'h40] = 8'h02;
        @(negedge clk);
        do_read(3, 8'h40);

        // Load on the completion edge: old value; load one edge earlier: new value
        do_load(8'h50, 8'h07);
        @(negedge clk);
        rd_valid[1] = 1'b1; rd_addr[1] = 8'h50;
        exp_q.push_back({2'd1, 8'h07});
        @(negedge clk);
        @(negedge clk);
        load_valid = 1'b1; load_addr = 8'h50; load_data = 8'h08;
        @(negedge clk);
        load_valid = 1'b0; rd_valid[1] = 1'b0;
        check("ld_hazard_ready", 32'(rd_ready[1]), 32'(1));
        model[8'h50] = 8'h08;
        @(negedge clk);
        do_read(1, 8'h50);
        do_load(8'h51, 8'h70);
        @(negedge clk);
        rd_valid[2] = 1'b1; rd_addr[2] = 8'h51;
        exp_q.push_back({2'd2, 8'h71});
        @(negedge clk);
        load_valid = 1'b1; load_addr = 8'h51; load_data = 8'h71;
        model[8'h51] = 8'h71;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        check("ld_early_ready", 32'(rd_ready[2]), 32'(1));
        rd_valid[2] = 1'b0;
        @(negedge clk);

        // Reset while read and write are in flight
        do_load(8'h60, 8'h5A);
        do_load(8'h61, 8'h66);
        b1 = wr_cnt[1];
        @(negedge clk);
        rd_valid[0] = 1'b1; rd_addr[0] = 8'h60;
        wr_valid[1] = 1'b1; wr_addr[1] = 8'h61; wr_data[1] = 8'hEE;
        @(negedge clk);
        reset = 1'b0; rd_valid[0] = 1'b0; wr_valid[1] = 1'b0;
        @(negedge clk);
        check("mid_rst_rd_ready", 32'(rd_ready), 32'(0));
        check("mid_rst_rd_data", 32'(rd_data), 32'(0));
        check("mid_rst_wr_ready", 32'(wr_ready), 32'(0));
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_no_wr_pulse", 32'(wr_cnt[1] - b1), 32'(0));
        check("mid_rst_data0", 32'(rd_data[0]), 32'(0));
        do_read(2, 8'h60);
        do_read(0, 8'h61);

        // Program memory: writes disabled, loads still work
        do_load_b(8'h05, 16'h1234);
        @(negedge clk);
        b_wr_valid[2] = 1'b1; b_wr_addr[2] = 8'h05; b_wr_data[2] = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("pm_wr_ready_%0d", i), 32'(b_wr_ready), 32'(0));
        end
        b_wr_valid[2] = 1'b0;
        do_read_b(2, 8'h05);
        do_load_b(8'h05, 16'hCAFE);
        do_read_b(2, 8'h05);

        // Random sequential traffic over a small preloaded window
        for (int i = 0; i < 8; i++) do_load(8'(8'h80 + i), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 24; i++) begin
            rc = $urandom_range(0, NC - 1);
            ra = 8'(8'h80 + $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(rc, ra, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
            else
                do_read(rc, ra);
        end

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Multi-channel memory model that serves the memory side of the GPU's arbitration controllers, answering per-channel read and write requests after a fixed latency. It holds a single shared storage array, and each channel has independent read and write request engines. Instances are used for both data memory and program memory; program memory sets WRITE_ENABLE=0. It sits directly below the program-memory and data-memory controllers, in testbench and top-level simulation.

## Interface
- ADDR_BITS, 8: address width; storage depth is 2^ADDR_BITS words.
- DATA_BITS, 8: word width (16 for program memory).
- NUM_CHANNELS, 4: number of independent request channels.
- LATENCY, 2: cycles from request acceptance to the ready pulse; must be ≥1.
- WRITE_ENABLE, 1: 0 disables channel writes (write engines tied off).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mem_read_valid  in  [NUM_CHANNELS]  per-channel read request.
- mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address; held stable while valid.
- mem_read_ready  out  [NUM_CHANNELS]  one-cycle completion pulse.
- mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data; valid during ready and held until the next completion.
- mem_write_valid  in  [NUM_CHANNELS]  per-channel write request.
- mem_write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address.
- mem_write_data  in  [DATA_BITS] x NUM_CHANNELS  write data.
- mem_write_ready  out  [NUM_CHANNELS]  one-cycle completion pulse.
- load_valid  in  1  preload strobe, bypassing channels; active even when WRITE_ENABLE=0.
- load_address  in  ADDR_BITS  preload address.
- load_data  in  DATA_BITS  preload data.

## Operation
- Each channel has one read FSM and one write FSM, both with states IDLE, BUSY and DONE.
- IDLE → BUSY when valid is sampled high. The address is latched, plus data for writes. The latency counter loads LATENCY-1.
- BUSY: the counter decrements each cycle. When the counter is 0, the FSM registers ready=1 and enters DONE.
  - Read: mem_read_data is registered from storage on the same edge.
  - Write: storage is written with the latched data on the same edge.
- DONE: ready=0. The FSM returns to IDLE on the first cycle valid is sampled low, and stays in DONE while valid remains high. This stops a requester that drops valid one cycle after seeing ready from issuing a duplicate request.
- Latched address and data are used; input changes during BUSY are ignored.
- Counter width is $clog2(LATENCY+1). There is no wrap; the counter stops at 0.
- Storage is written only at write completion or by a load.
- Same-edge write collisions on the same address resolve in this priority order: load, then the lowest-index channel write, then higher-index channel writes (discarded).
- Read/write hazard on the same edge: a read completing on the same edge as a write or load to the same address returns the old value (read-before-write).
- With WRITE_ENABLE=0, the write FSMs stay in IDLE, mem_write_ready stays at 0, and mem_write_* inputs are ignored.
- Reset (mid-operation included):
  - All FSMs go to IDLE and counters clear.
  - mem_read_ready, mem_write_ready and every mem_read_data entry are 0.
  - In-flight requests are dropped with no storage update.
  - Storage contents are preserved (not reset).

## Timing
- A request sampled at edge t produces ready high from edge t+LATENCY to edge t+LATENCY+1.
- Minimum per-channel request spacing is LATENCY+2 edges when valid drops immediately after ready.
- A load at edge t is visible to a read completing at edge t+1 or later.
- All outputs are registered; there is no combinational input-to-output path.
- Channels are fully independent, with no cross-channel stalls.

## Structure
- Package gpu_mem_pkg holds the typedef enum mem_chan_state_t {IDLE, BUSY, DONE} and the default LATENCY constant.
- Sub-module mem_channel_fsm (state, counter, latched address/data, ready) is instantiated 2×NUM_CHANNELS times.
- The top level owns the storage array, write-priority resolution and read-data registers.

## Test plan
Defaults: ADDR_BITS=8, DATA_BITS=8, NUM_CHANNELS=4, LATENCY=2 unless stated.
- Preload addr 0x10=0xA5; ch0 read 0x10 sampled at edge t → mem_read_ready[0]=1 exactly at t+2, data 0xA5; ready=0 at t+3.
- ch1 write 0x20=0x3C, valid held 3 cycles after ready → one ready pulse, FSM stays DONE, no second write; a later read of 0x20 returns 0x3C.
- ch0 and ch2 write addr 0x30 (0x11, 0x22) completing on the same edge → memory 0x30=0x11; both readies pulse.
- ch3 read 0x40 (old 0x01) completes on the same edge as ch0's write of 0x40=0x02 → read data 0x01; the next read returns 0x02.
- Reset asserted while ch0 read is BUSY → ready never pulses, mem_read_data[0]=0; preloaded storage is unchanged after reset.
- WRITE_ENABLE=0, DATA_BITS=16: ch2 write valid held 10 cycles → mem_write_ready=0 throughout and storage unchanged; a load still writes.
